shared_resource_arbiter: RTL and testbench
==========================================

Name: shared_resource_arbiter

Overview:
- Responder side of the pipeline-to-shared-resource interface.
- Arbitrates round-robin among NUM_REQ pipelines that drive req/valid/data and wait on grant.
- Pushes the granted beat through a fixed-latency resource datapath, result = data + 1.
- Returns the result on a shared bus with a per-requester one-cycle valid strobe, which feeds each pipeline's valid-from-resource input.

Parameters:
- NUM_REQ, 2, number of requesting pipelines (2..8).
- DATA_W, 32, beat and result width.
- LATENCY, 3, cycles from accept edge to result_valid (1..8).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req  in  NUM_REQ  per-requester arbitration request.
- valid_in  in  NUM_REQ  per-requester beat valid.
- data_in  in  NUM_REQ*DATA_W  packed beats; requester i occupies bits [i*DATA_W +: DATA_W].
- grant  out  NUM_REQ  registered grant, one-hot or zero.
- result  out  DATA_W  shared result bus.
- result_valid  out  NUM_REQ  one-hot strobe; bit i marks result as belonging to requester i.
- busy  out  1  high while any beat is in flight.

Behaviour:
- Reset (reset=0, async): grant=0, result=0, result_valid=0, busy=0, round-robin pointer=0, all in-flight slots cleared. Any in-flight beat at reset is discarded and never returned.
- Transfer: occurs at a rising edge where grant[i] & valid_in[i] for the granted i. A valid without grant is ignored. Requesters hold data while not granted. At most one transfer per cycle.
- Arbitration (registered):
  - next grant = first requester with req set, searching from the pointer upward with wrap.
  - No req set: grant=0 next cycle.
  - Pointer advances to (grantee+1) mod NUM_REQ when the grantee transfers, or when the grantee has req=1 and valid_in=0 and another requester has req=1. Otherwise the grantee keeps grant.
  - A single active requester keeps grant indefinitely; a transfer is possible every cycle.
  - Grantee drops req: grant falls at the next edge. Any transfer in the current cycle still uses the current grant.
- Datapath:
  - LATENCY-stage shift pipeline of {valid, tag[log2 NUM_REQ], data}.
  - Accepted data is captured at the accept edge T. result = captured data + 1, modulo 2^DATA_W (all-ones wraps to 0).
  - result and result_valid[tag] are registered and visible for exactly one cycle after edge T+LATENCY-1, i.e. LATENCY cycles after the accept cycle.
  - Fully pipelined: back-to-back accepts give back-to-back results in accept order.
  - result holds its last value when result_valid=0.
- No result backpressure: requesters must always accept result_valid.
- busy = OR of the pipeline-slot valids, registered together with the slots. busy=1 from the edge after the accept until the slot that produced the final result_valid clears.
- Reset mid-operation: all slots cleared immediately, grant=0, pointer=0.

Optional Feature:
- Macro: RES_FLUSH_EN.
- Defined:
  - Adds input flush_in [NUM_REQ].
  - flush_in[i]=1 at an edge clears every in-flight slot tagged i, so no result_valid[i] is produced for those beats.
  - A transfer from requester i in that same cycle is also dropped; its grant is still consumed and the pointer still advances.
  - Slots for other requesters are unaffected.
- Not defined: no flush_in port; every accepted beat is returned.

Test Plan:
- Reset: hold reset=0 with req=2'b11 -> grant=0, result_valid=0, busy=0. Release reset -> grant=2'b01 one edge later.
- Single requester: req=01, valid_in=01, data0=0x0000_0010 accepted at cycle 5 -> result=0x0000_0011 with result_valid=01 at cycle 8 (LATENCY=3), one cycle wide. busy high cycles 6-8.
- Round-robin: req=11, valid=11 continuously -> grant alternates 01,10,01,10. Results alternate tags in accept order with one result per cycle.
- Idle grantee: req=11, valid=10 while grant=01 -> grant moves to 10 next cycle; no transfer occurs from requester 0.
- Wrap: data0=0xFFFF_FFFF -> result=0x0000_0000, result_valid=01.
- RES_FLUSH_EN: two beats in flight for requester 1, pulse flush_in=10 -> no result_valid[1] for them. Concurrent requester-0 beat 0x5 still returns 0x6.

Source files
------------

// File: rtl/shared_resource_arbiter.sv
// shared_resource_arbiter
// Responder side of the pipeline-to-shared-resource link. Round-robin
// arbitration among NUM_REQ requesters, a LATENCY-deep result pipeline
// computing data + 1, and a shared result bus with a per-requester strobe.
//
// Optional build macro: RES_FLUSH_EN
//   Adds flush_in[NUM_REQ]. A set bit kills every in-flight beat tagged with
//   that requester, including a beat transferred on the same edge.
//
// Arbitration state: grant register (one-hot or zero) and round-robin pointer.

module shared_resource_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        valid_in,
    input  logic [NUM_REQ*DATA_W-1:0] data_in,
`ifdef RES_FLUSH_EN
    input  logic [NUM_REQ-1:0]        flush_in,
`endif
    output logic [NUM_REQ-1:0]        grant,
    output logic [DATA_W-1:0]         result,
    output logic [NUM_REQ-1:0]        result_valid,
    output logic                      busy
);

    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [TAG_W-1:0]   ptr_q;
    logic [TAG_W-1:0]   ptr_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [TAG_W-1:0]   grant_idx;
    logic [DATA_W-1:0]  sel_data;
    logic               xfer;
    logic               grantee_req;
    logic               grantee_idle;
    logic               other_req;
    logic               advance;
    logic [NUM_REQ-1:0] flush_vec;

    logic [LATENCY-1:0] slot_v;
    logic [LATENCY-1:0] nxt_v;
    logic [TAG_W-1:0]   slot_tag  [LATENCY];
    logic [TAG_W-1:0]   nxt_tag   [LATENCY];
    logic [DATA_W-1:0]  slot_data [LATENCY];
    logic [DATA_W-1:0]  nxt_data  [LATENCY];

`ifdef RES_FLUSH_EN
    assign flush_vec = flush_in;
`else
    assign flush_vec = '0;
`endif

    // Decode the current grantee: its index and the beat it is presenting.
    always_comb begin
        grant_idx = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = TAG_W'(i);
                sel_data  = data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    assign xfer         = |(grant & valid_in);
    assign grantee_req  = |(grant & req);
    assign grantee_idle = |(grant & req & ~valid_in);
    assign other_req    = |(req & ~grant);
    // Pass the grant on after a transfer, or when the grantee is holding the
    // grant without data while someone else is waiting.
    assign advance      = xfer | (grantee_idle & other_req);

    // Arbitration state register: grant and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant <= '0;
            ptr_q <= '0;
        end else begin
            grant <= grant_d;
            ptr_q <= ptr_d;
        end
    end

    // Next pointer and next grant: keep a still-requesting grantee unless it
    // advances, otherwise search upward from the (possibly updated) pointer.
    always_comb begin
        int  idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        ptr_d   = ptr_q;
        grant_d = '0;
        if (advance) begin
            ptr_d = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
        end
        if (grantee_req && !advance) begin
            grant_d = grant;
        end else begin
            for (int off = 0; off < NUM_REQ; off++) begin
                idx = (int'(ptr_d) + off) % NUM_REQ;
                if (!found && req[idx]) begin
                    grant_d[idx] = 1'b1;
                    found        = 1'b1;
                end
            end
        end
    end

    // Next pipeline contents: shift by one, drop flushed beats, increment
    // on entry to the final (output) slot.
    always_comb begin
        nxt_v       = '0;
        nxt_v[0]    = xfer & ~(|(grant & flush_vec));
        nxt_tag[0]  = grant_idx;
        nxt_data[0] = sel_data;
        for (int k = 1; k < LATENCY; k++) begin
            nxt_v[k]    = slot_v[k-1];
            nxt_tag[k]  = slot_tag[k-1];
            nxt_data[k] = slot_data[k-1];
            for (int i = 0; i < NUM_REQ; i++) begin
                if (flush_vec[i] && (slot_tag[k-1] == TAG_W'(i))) begin
                    nxt_v[k] = 1'b0;
                end
            end
        end
        nxt_data[LATENCY-1] = nxt_data[LATENCY-1] + DATA_W'(1);
    end

    // Pipeline slots and busy flag; data only loads with a live beat so the
    // output slot holds the last result between strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_v <= '0;
            busy   <= 1'b0;
            for (int k = 0; k < LATENCY; k++) begin
                slot_tag[k]  <= '0;
                slot_data[k] <= '0;
            end
        end else begin
            slot_v <= nxt_v;
            busy   <= |nxt_v;
            for (int k = 0; k < LATENCY; k++) begin
                slot_tag[k] <= nxt_tag[k];
                if (nxt_v[k]) begin
                    slot_data[k] <= nxt_data[k];
                end
            end
        end
    end

    assign result = slot_data[LATENCY-1];

    // Result strobe: one-hot decode of the output slot's tag.
    always_comb begin
        result_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (slot_v[LATENCY-1] && (slot_tag[LATENCY-1] == TAG_W'(i))) begin
                result_valid[i] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shared_resource_arbiter.sv
// Directed bench for shared_resource_arbiter (NUM_REQ=2, DATA_W=32, LATENCY=3).
module tb_shared_resource_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  valid_in;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [63:0] data_in;
    logic [1:0]  grant;
    logic [31:0] result;
    logic [1:0]  result_valid;
    logic        busy;
`ifdef RES_FLUSH_EN
    logic [1:0]  flush_in;
`endif

    int checks   = 0;
    int failures = 0;

    assign data_in = {d1, d0};

    shared_resource_arbiter #(.NUM_REQ(2), .DATA_W(32), .LATENCY(3)) dut (
`ifdef RES_FLUSH_EN
        .flush_in(flush_in),
`endif
        .clk(clk),
        .reset(reset),
        .req(req),
        .valid_in(valid_in),
        .data_in(data_in),
        .grant(grant),
        .result(result),
        .result_valid(result_valid),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        req      = 2'b11;
        valid_in = 2'b00;
        d0       = '0;
        d1       = '0;
`ifdef RES_FLUSH_EN
        flush_in = 2'b00;
`endif
        // Reset held with both requesting
        tick();
        tick();
        chk("rst_grant", grant, 2'b00);
        chk("rst_rv", result_valid, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_result", result, 32'h0);
        reset = 1'b1;
        tick();
        chk("post_rst_grant", grant, 2'b01);
        req = 2'b00;
        tick();
        chk("drop_req_grant", grant, 2'b00);

        // Single requester, data 0x10
        req = 2'b01;
        tick();
        chk("single_grant", grant, 2'b01);
        valid_in = 2'b01;
        d0 = 32'h0000_0010;
        tick();
        chk("single_busy_t1", busy, 1'b1);
        chk("single_keep_grant", grant, 2'b01);
        chk("single_rv_t1", result_valid, 2'b00);
        valid_in = 2'b00;
        tick();
        chk("single_busy_t2", busy, 1'b1);
        chk("single_rv_t2", result_valid, 2'b00);
        tick();
        chk("single_rv_t3", result_valid, 2'b01);
        chk("single_result", result, 32'h0000_0011);
        chk("single_busy_t3", busy, 1'b1);
        tick();
        chk("single_rv_t4", result_valid, 2'b00);
        chk("single_busy_t4", busy, 1'b0);
        chk("single_hold", result, 32'h0000_0011);

        // All-ones wraps to zero
        valid_in = 2'b01;
        d0 = 32'hFFFF_FFFF;
        tick();
        valid_in = 2'b00;
        tick();
        tick();
        chk("wrap_rv", result_valid, 2'b01);
        chk("wrap_result", result, 32'h0000_0000);
        tick();
        chk("wrap_rv_off", result_valid, 2'b00);

        // Idle grantee yields to the other requester without a transfer
        req = 2'b11;
        valid_in = 2'b10;
        tick();
        chk("idle_grant", grant, 2'b10);
        chk("idle_busy", busy, 1'b0);

        // Round robin with continuous valids
        valid_in = 2'b11;
        d0 = 32'h0000_00A0;
        d1 = 32'h0000_00B0;
        tick();
        chk("rr_grant_e1", grant, 2'b01);
        d1 = 32'h0000_00B1;
        tick();
        chk("rr_grant_e2", grant, 2'b10);
        d0 = 32'h0000_00A1;
        tick();
        chk("rr_grant_e3", grant, 2'b01);
        chk("rr_rv_e3", result_valid, 2'b10);
        chk("rr_res_e3", result, 32'h0000_00B1);
        tick();
        chk("rr_grant_e4", grant, 2'b10);
        chk("rr_rv_e4", result_valid, 2'b01);
        chk("rr_res_e4", result, 32'h0000_00A1);
        req = 2'b00;
        valid_in = 2'b00;
        tick();
        chk("rr_grant_e5", grant, 2'b00);
        chk("rr_rv_e5", result_valid, 2'b10);
        chk("rr_res_e5", result, 32'h0000_00B2);
        tick();
        chk("rr_rv_e6", result_valid, 2'b01);
        chk("rr_res_e6", result, 32'h0000_00A2);
        chk("rr_busy_e6", busy, 1'b1);
        tick();
        chk("rr_rv_e7", result_valid, 2'b00);
        chk("rr_busy_e7", busy, 1'b0);

`ifdef RES_FLUSH_EN
        // Two requester-1 beats in flight, flushed while requester 0 transfers
        req = 2'b10;
        tick();
        chk("fl_grant_g", grant, 2'b10);
        valid_in = 2'b10;
        d1 = 32'h0000_0100;
        tick();
        chk("fl_grant_f1", grant, 2'b10);
        req = 2'b11;
        valid_in = 2'b11;
        d1 = 32'h0000_0101;
        d0 = 32'h0000_0005;
        tick();
        chk("fl_grant_f2", grant, 2'b01);
        req = 2'b01;
        valid_in = 2'b01;
        flush_in = 2'b10;
        tick();
        chk("fl_rv_f3", result_valid, 2'b00);
        flush_in = 2'b00;
        req = 2'b00;
        valid_in = 2'b00;
        tick();
        chk("fl_rv_f4", result_valid, 2'b00);
        chk("fl_busy_f4", busy, 1'b1);
        tick();
        chk("fl_rv_f5", result_valid, 2'b01);
        chk("fl_res_f5", result, 32'h0000_0006);
        tick();
        chk("fl_busy_f6", busy, 1'b0);
        chk("fl_rv_f6", result_valid, 2'b00);
`endif

        // Reset with a beat in flight discards it
        req = 2'b01;
        tick();
        chk("mr_grant", grant, 2'b01);
        valid_in = 2'b01;
        d0 = 32'h0000_0077;
        tick();
        chk("mr_busy", busy, 1'b1);
        req = 2'b00;
        valid_in = 2'b00;
        reset = 1'b0;
        #2;
        chk("mr_grant_rst", grant, 2'b00);
        chk("mr_busy_rst", busy, 1'b0);
        chk("mr_result_rst", result, 32'h0);
        reset = 1'b1;
        tick();
        tick();
        chk("mr_rv_a", result_valid, 2'b00);
        tick();
        chk("mr_rv_b", result_valid, 2'b00);
        chk("mr_result_b", result, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
